// File: rtl/nibble_add_seq_if.sv
// Operand/result bundle for the slice-serial adder: requester drives start/sub/a/b,
// the adder returns busy/done and the registered result flags.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  // Handshake: start is sampled on a rising edge only while the adder is idle or
  // showing done; busy marks the RUN cycles, done is a one-cycle result-valid pulse.
  modport master (
    output start, sub, a, b,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Slice-serial add/subtract: one 4-bit block carry-lookahead adder is reused for
// every nibble, LSB first, with the inter-slice carry held in a register.
module bcla_add_4 (
  output logic [3:0] sum,
  output logic       g,
  output logic       p,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);
  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi   = a & b;
  assign pi   = a ^ b;
  assign c[0] = c_in;
  assign c[1] = gi[0] | (pi[0] & c_in);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c_in);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & c_in);
  assign sum  = pi ^ c;
  assign g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p    = &pi;
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_add_seq_if.slave      bus,
  output logic [1:0]           dbg_state
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [3:0] a_sl;
  logic [3:0] b_sl;
  logic [3:0] add_sum;
  logic       add_g;
  logic       add_p;
  logic       slice_cout;
  logic       last_slice;
  logic       accept;

  assign a_sl = a_q[4*int'(idx_q) +: 4];
  assign b_sl = b_q[4*int'(idx_q) +: 4];

  bcla_add_4 u_add (
    .sum  (add_sum),
    .g    (add_g),
    .p    (add_p),
    .a    (a_sl),
    .b    (b_sl),
    .c_in (carry_q)
  );

  assign slice_cout = add_g | (add_p & carry_q);
  assign last_slice = (idx_q == LAST_IDX);
  assign accept     = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

  // State register; the datapath registers share the same asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (accept) begin
      // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      sum_d[4*int'(idx_q) +: 4] = add_sum;
      carry_d = slice_cout;
      idx_d   = last_slice ? '0 : idx_q + IDX_W'(1);
      if (last_slice) begin
        c_out_d = slice_cout;
        ovf_d   = (a_q[W-1] ^ b_q[W-1] ^ add_sum[3]) ^ slice_cout;
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq (NIBBLES=4): directed corner cases then random add/sub
// traffic, each result compared with an arithmetic reference model.
module tb_nibble_add_seq;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_err    = 0;
  logic [W+1:0] exp_q[$];

  nibble_add_seq_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference: {ovf, c_out, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, sr;
    logic [W-1:0] sm;
    logic co, ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      sm = x - y;
      co = (x >= y);
      sr = sx - sy;
    end else begin
      sm = x + y;
      co = ((32'(x) + 32'(y)) >> W) != 0;
      sr = sx + sy;
    end
    ov = (sr > (2**(W-1) - 1)) || (sr < -(2**(W-1)));
    return {ov, co, sm};
  endfunction

  // driver: call at a negedge; returns just after the accepting posedge
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W+1:0] e);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = x;
    bus.b     = y;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // waits (bounded) for done; inj>0 pulses a stray start at that RUN negedge
  task automatic collect(input string tag, input int inj);
    int lat;
    int busy_n;
    bit seen;
    logic [W+1:0] e;
    lat = 0; busy_n = 0; seen = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      if (inj != 0 && k == inj) begin
        bus.start = 1'b1;
        bus.sub   = ~bus.sub;
        bus.a     = 16'hAAAA;
        bus.b     = 16'hAAAA;
      end else if (inj != 0 && k == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1;
        lat  = k;
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      end else if (bus.busy) begin
        busy_n++;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, 32'(bus.sum), 32'(e[W-1:0]));
    check({tag, "_c_out"}, 32'(bus.c_out), 32'(e[W]));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(e[W+1]));
  endtask

  task automatic op(input string tag, input logic s, input logic [W-1:0] x,
                    input logic [W-1:0] y, input logic [W+1:0] e);
    @(negedge clk);
    issue(s, x, y, e);
    collect(tag, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic s_r;
    logic [W-1:0] a_r, b_r;

    rst_n = 1'b0; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);

    // first start right after reset release is accepted on the next edge
    rst_n = 1'b1;
    issue(1'b0, 16'h1234, 16'h4321, {2'b00, 16'h5555});
    collect("add_basic", 0);
    @(negedge clk);
    check("add_basic_done_one_cycle", 32'(bus.done), 32'd0);

    op("add_wrap",    1'b0, 16'hFFFF, 16'h0001, {1'b0, 1'b1, 16'h0000});
    op("add_ovf",     1'b0, 16'h7FFF, 16'h0001, {1'b1, 1'b0, 16'h8000});
    op("sub_borrow",  1'b1, 16'h0005, 16'h0007, {1'b0, 1'b0, 16'hFFFE});
    op("sub_ovf",     1'b1, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h7FFF});

    // stray start during RUN is ignored
    @(negedge clk);
    issue(1'b0, 16'h1234, 16'h4321, {2'b00, 16'h5555});
    collect("start_in_run", 2);

    // start held through DONE: second op accepted with no idle cycle
    @(negedge clk);
    issue(1'b0, 16'h1234, 16'h4321, {2'b00, 16'h5555});
    collect("b2b_first", 0);
    issue(1'b0, 16'h0001, 16'h0001, {2'b00, 16'h0002});
    collect("b2b_second", 0);

    // reset in the third RUN cycle
    @(negedge clk);
    issue(1'b0, 16'h1234, 16'h4321, '0);
    void'(exp_q.pop_back());
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy",  32'(bus.busy),  32'd0);
    check("midrun_rst_done",  32'(bus.done),  32'd0);
    check("midrun_rst_sum",   32'(bus.sum),   32'd0);
    check("midrun_rst_c_out", 32'(bus.c_out), 32'd0);
    check("midrun_rst_ovf",   32'(bus.ovf),   32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrun_rst_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    op("after_rst", 1'b0, 16'h00FF, 16'h0001, {2'b00, 16'h0100});

    // random traffic, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      s_r = 1'($urandom_range(0, 1));
      a_r = W'($urandom);
      b_r = W'($urandom);
      if (i == 0 || $urandom_range(0, 1) == 0) @(negedge clk);
      issue(s_r, a_r, b_r, model(s_r, a_r, b_r));
      collect($sformatf("rand%0d", i), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL provide parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request a new operation; sampled on the rising edge.
REQ-005 SHALL have port sub, input, 1, operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have ports a and b, input, W each, operands; sampled with start.
REQ-007 SHALL have port busy, output, 1, high while slices are being computed.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking the result valid.
REQ-009 SHALL have port sum, output, W, result register.
REQ-010 SHALL have port c_out, output, 1, carry out of the MSB; for sub, 1 = no borrow.
REQ-011 SHALL have port ovf, output, 1, two's-complement signed overflow flag.

Function
REQ-012 SHALL instantiate exactly one 4-bit block carry-lookahead adder (team BCLA_ADD_4: sum, g, p, a, b, c_in) and time-share it across all slices; no other adder logic is allowed.
REQ-013 SHALL compute slice carry-out as g | (p & c_in) and register it as the carry for the next slice.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state is IDLE.
REQ-015 IDLE: start=1 -> latch a, latch b (bitwise inverted if sub=1), set carry register = sub, set slice index = 0, go to RUN.
REQ-016 RUN: on each edge, write adder output into sum slice [index], update the carry register, and increment index; after slice NIBBLES-1, go to DONE.
REQ-017 Slice order SHALL be LSB first; operation occupies exactly NIBBLES RUN cycles.
REQ-018 busy SHALL be 1 only in RUN.
REQ-019 done SHALL be 1 only in DONE, for exactly one cycle, asserted NIBBLES+1 cycles after the accepting edge.
REQ-020 DONE -> IDLE when start=0; DONE with start=1 SHALL accept the new operation directly (-> RUN), giving back-to-back throughput of NIBBLES+1 cycles.
REQ-021 start in RUN SHALL be ignored, with no effect on state, operands, or outputs.
REQ-022 c_out SHALL equal the final registered carry.
REQ-023 ovf SHALL equal (carry into MSB) XOR c_out, where carry into MSB = a'[W-1] ^ b'[W-1] ^ sum[W-1] and a', b' are the latched operands.
REQ-024 sum, c_out, and ovf SHALL be updated only by an operation and hold their values until the next accepted start; during RUN, sum holds partial results and is not valid.
REQ-025 Index wrap: the index SHALL never exceed NIBBLES-1; it is reloaded to 0 on every accept.

Reset
REQ-026 rst_n=0 at any time, including mid-RUN, SHALL immediately force IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, and clear index, carry, and operand registers.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification (NIBBLES=4)
REQ-028 start, sub=0, a=0x1234, b=0x4321 -> done 5 cycles later; sum=0x5555, c_out=0, ovf=0; busy high for 4 cycles.
REQ-029 sub=0, a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0; then a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
REQ-030 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, ovf=0; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
REQ-031 start pulsed again with a=0xAAAA in the 2nd RUN cycle of 0x1234+0x4321 -> ignored; the result is still 0x5555 at the original done time.
REQ-032 start held high through DONE with new operands 0x0001+0x0001 -> no IDLE cycle between operations; the second done comes 5 cycles after the first, with sum=0x0002.
REQ-033 rst_n low in the 3rd RUN cycle -> all outputs 0 asynchronously; no done pulse; a following operation 0x00FF+0x0001 completes with sum=0x0100.
